// File: rtl/s2m_pkg.sv
// ---------------------------------------------------------------------------
// s2m_pkg
// Shared constants for the slave-to-master (s2m) collection path.
//   S2M_WIDTH          data bits per record
//   S2M_DEPTH          destination (master memory) address bits per record
//   S2M_FIFO_BITS      log2 of responder FIFO entries
//   REC_W              packed record width, {addr, data} with addr in the MSBs
//   RESPONDER_LATENCY  edges from a sampled poll to r_valid being registered;
//                      the harvester delays its core select to match this
// ---------------------------------------------------------------------------
package s2m_pkg;

  localparam int S2M_WIDTH         = 32;
  localparam int S2M_DEPTH         = 8;
  localparam int S2M_FIFO_BITS     = 4;
  localparam int REC_W             = S2M_WIDTH + S2M_DEPTH;
  localparam int RESPONDER_LATENCY = 2;

  // Record layout at the default widths.
  typedef struct packed {
    logic [S2M_DEPTH-1:0] addr;
    logic [S2M_WIDTH-1:0] data;
  } s2m_rec_t;

endpackage : s2m_pkg

// File: rtl/s2m_responder_if.sv
// ---------------------------------------------------------------------------
// s2m_responder_if
// Groups the core write port, FIFO status and the harvester poll/response
// signals of one s2m_responder.
//   w_addr, w_data, we     core write of one {addr, data} record
//   full, overflow, count  FIFO status back to the core
//   r_req                  this core's bit of the harvester poll vector
//   r_data, r_valid        popped record and its one-cycle strobe
// Modports:
//   master  the core + harvester side (drives writes and polls)
//   slave   the responder itself
// ---------------------------------------------------------------------------
interface s2m_responder_if
  import s2m_pkg::*;
#(
  parameter int WIDTH     = S2M_WIDTH,
  parameter int DEPTH     = S2M_DEPTH,
  parameter int FIFO_BITS = S2M_FIFO_BITS
);

  logic [DEPTH-1:0]       w_addr;
  logic [WIDTH-1:0]       w_data;
  logic                   we;
  logic                   full;
  logic                   overflow;
  logic [FIFO_BITS:0]     count;
  logic                   r_req;
  logic [WIDTH+DEPTH-1:0] r_data;
  logic                   r_valid;

  modport master (
    output w_addr, w_data, we, r_req,
    input  full, overflow, count, r_data, r_valid
  );

  modport slave (
    input  w_addr, w_data, we, r_req,
    output full, overflow, count, r_data, r_valid
  );

endinterface : s2m_responder_if

// File: rtl/s2m_fifo_ram.sv
// ---------------------------------------------------------------------------
// s2m_fifo_ram
// Simple dual-port record store: one write port, one synchronous read port.
// No reset on the array or the read register so it maps onto block or
// distributed RAM.
//   clk     clock
//   we      write enable; w_rec stored at w_addr
//   re      read enable; r_rec <= mem[r_addr] at the edge
//   r_rec   registered read data (holds when re=0)
// ---------------------------------------------------------------------------
module s2m_fifo_ram
  import s2m_pkg::*;
#(
  parameter int REC_BITS  = REC_W,
  parameter int ADDR_BITS = S2M_FIFO_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] w_addr,
  input  logic [REC_BITS-1:0]  w_rec,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] r_addr,
  output logic [REC_BITS-1:0]  r_rec
);

  logic [REC_BITS-1:0] mem [2**ADDR_BITS];

  // Read and write never target the same entry in one edge: a pop needs
  // count!=0 and a write needs count!=capacity, so equal pointers cannot
  // see both at once.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_rec;
    end
    if (re) begin
      r_rec <= mem[r_addr];
    end
  end

endmodule : s2m_fifo_ram

// File: rtl/s2m_responder.sv
// ---------------------------------------------------------------------------
// s2m_responder
// Core-side end of the s2m collection path. Buffers {addr, data} records
// written by the local core and answers each harvester poll pulse by popping
// one record and presenting it on r_data with a one-cycle r_valid strobe,
// RESPONDER_LATENCY edges after the poll was sampled.
//   clk    clock
//   reset  asynchronous, active-low reset (deassertion synchronized outside)
//   bus    s2m_responder_if.slave: core write port, FIFO status, poll/response
// ---------------------------------------------------------------------------
module s2m_responder
  import s2m_pkg::*;
#(
  parameter int WIDTH     = S2M_WIDTH,
  parameter int DEPTH     = S2M_DEPTH,
  parameter int FIFO_BITS = S2M_FIFO_BITS
) (
  input  logic             clk,
  input  logic             reset,
  s2m_responder_if.slave   bus
);

  localparam int                RW    = WIDTH + DEPTH;
  localparam int                CNT_W = FIFO_BITS + 1;
  localparam logic [CNT_W-1:0]  CAP   = CNT_W'(1) << FIFO_BITS;

  logic [FIFO_BITS-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_BITS-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 overflow_reg, overflow_next;

  logic                 full;
  logic                 do_write;
  logic                 do_pop;

  // Output pipeline: ram_valid_reg tracks the RAM read register (edge N),
  // s1_* is stage 1 (edge N+1), r_* is the registered output (edge N+2).
  logic                 ram_valid_reg;
  logic [RW-1:0]        ram_rec;
  logic                 s1_valid_reg;
  logic [RW-1:0]        s1_data_reg;
  logic                 r_valid_reg;
  logic [RW-1:0]        r_data_reg;

  assign full     = (count_reg == CAP);
  assign do_write = bus.we & ~full;
  // Pop decision uses the registered count, so a write landing on the same
  // edge into an empty FIFO is not visible to this poll.
  assign do_pop   = bus.r_req & (count_reg != '0);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (do_write) begin
      wr_ptr_next = wr_ptr_reg + FIFO_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + FIFO_BITS'(1);
    end
    if (bus.we && full) begin
      overflow_next = 1'b1;
    end

    unique case ({do_write, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  s2m_fifo_ram #(
    .REC_BITS  (RW),
    .ADDR_BITS (FIFO_BITS)
  ) u_ram (
    .clk    (clk),
    .we     (do_write),
    .w_addr (wr_ptr_reg),
    .w_rec  ({bus.w_addr, bus.w_data}),
    .re     (do_pop),
    .r_addr (rd_ptr_reg),
    .r_rec  (ram_rec)
  );

  // Valid bits are reset asynchronously so an in-flight pop is killed the
  // moment reset asserts; the RAM read register is left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_valid_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      r_valid_reg   <= 1'b0;
      r_data_reg    <= '0;
    end else begin
      ram_valid_reg <= do_pop;
      s1_valid_reg  <= ram_valid_reg;
      if (ram_valid_reg) begin
        s1_data_reg <= ram_rec;
      end
      r_valid_reg   <= s1_valid_reg;
      // r_data holds its last record between strobes.
      if (s1_valid_reg) begin
        r_data_reg <= s1_data_reg;
      end
    end
  end

  assign bus.full     = full;
  assign bus.overflow = overflow_reg;
  assign bus.count    = count_reg;
  assign bus.r_valid  = r_valid_reg;
  assign bus.r_data   = r_data_reg;

endmodule : s2m_responder

// File: tb/tb_s2m_responder.sv
// ---------------------------------------------------------------------------
// tb_s2m_responder
// Directed bench for s2m_responder: writes, polls, full/overflow, same-edge
// write+pop, write into empty on a poll edge, and reset during a pop.
// ---------------------------------------------------------------------------
module tb_s2m_responder;
  import s2m_pkg::*;

  localparam int LAT = RESPONDER_LATENCY;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  s2m_responder_if #(
    .WIDTH     (32),
    .DEPTH     (8),
    .FIFO_BITS (4)
  ) bus ();

  s2m_responder #(
    .WIDTH     (32),
    .DEPTH     (8),
    .FIFO_BITS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rec(input logic [7:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic write_rec(input logic [7:0] a, input logic [31:0] d);
    bus.we     = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    tick();
    bus.we     = 1'b0;
  endtask

  // Single poll from idle: r_valid must stay low through edges N..N+LAT-1
  // and be high with the record right after edge N+LAT, then drop.
  task automatic poll_expect(input string tag, input logic [39:0] exp);
    bus.r_req = 1'b1;
    tick();
    bus.r_req = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk({tag, "_early_valid"}, 64'(bus.r_valid), 64'(0));
      tick();
    end
    chk({tag, "_valid"}, 64'(bus.r_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.r_data), 64'(exp));
    tick();
    chk({tag, "_valid_drop"}, 64'(bus.r_valid), 64'(0));
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    bus.we     = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.r_req  = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_r_valid",  64'(bus.r_valid),  64'(0));
    chk("rst_r_data",   64'(bus.r_data),   64'(0));
    chk("rst_count",    64'(bus.count),    64'(0));
    chk("rst_full",     64'(bus.full),     64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    reset = 1'b1;
    tick();

    // Basic write then poll, with latency checked edge by edge
    write_rec(8'h05, 32'hDEADBEEF);
    chk("t1_count_after_write", 64'(bus.count), 64'(1));
    bus.r_req = 1'b1;
    tick();                                   // edge N
    bus.r_req = 1'b0;
    chk("t1_count_after_pop", 64'(bus.count), 64'(0));
    chk("t1_valid_n",   64'(bus.r_valid), 64'(0));
    tick();                                   // edge N+1
    chk("t1_valid_n1",  64'(bus.r_valid), 64'(0));
    tick();                                   // edge N+2
    chk("t1_valid_n2",  64'(bus.r_valid), 64'(1));
    chk("t1_data_n2",   64'(bus.r_data),  64'h05_DEADBEEF);
    tick();
    chk("t1_valid_n3",  64'(bus.r_valid), 64'(0));
    chk("t1_data_hold", 64'(bus.r_data),  64'h05_DEADBEEF);

    // Poll with FIFO empty
    bus.r_req = 1'b1;
    tick();
    bus.r_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_empty_valid_%0d", i), 64'(bus.r_valid), 64'(0));
      chk($sformatf("t2_empty_count_%0d", i), 64'(bus.count),   64'(0));
      tick();
    end

    // Fill to capacity, one extra write is dropped
    for (int i = 0; i < 17; i++) begin
      write_rec(8'(i), 32'(i));
      if (i == 14) chk("t3_full_at_15", 64'(bus.full), 64'(0));
      if (i == 15) begin
        chk("t3_full_at_16",     64'(bus.full),     64'(1));
        chk("t3_count_at_16",    64'(bus.count),    64'(16));
        chk("t3_overflow_at_16", 64'(bus.overflow), 64'(0));
      end
    end
    chk("t3_overflow_set", 64'(bus.overflow), 64'(1));
    chk("t3_count_capped", 64'(bus.count),    64'(16));
    chk("t3_full_held",    64'(bus.full),     64'(1));

    // 17 back-to-back polls: 16 records in order, the last slot empty
    for (int c = 0; c < 20; c++) begin
      bus.r_req = (c < 17);
      tick();
      if (c < 16) chk($sformatf("t3_count_c%0d", c), 64'(bus.count), 64'(15 - c));
      if (c >= 2 && c <= 17) begin
        chk($sformatf("t3_valid_c%0d", c), 64'(bus.r_valid), 64'(1));
        chk($sformatf("t3_data_c%0d", c),  64'(bus.r_data),  64'(rec(8'(c - 2), 32'(c - 2))));
      end else begin
        chk($sformatf("t3_valid_c%0d", c), 64'(bus.r_valid), 64'(0));
      end
    end
    bus.r_req = 1'b0;
    chk("t3_count_drained", 64'(bus.count),    64'(0));
    chk("t3_full_drained",  64'(bus.full),     64'(0));
    chk("t3_overflow_kept", 64'(bus.overflow), 64'(1));

    // Write and pop on the same edge with count=3
    write_rec(8'h10, 32'd100);
    write_rec(8'h11, 32'd101);
    write_rec(8'h12, 32'd102);
    chk("t4_count_3", 64'(bus.count), 64'(3));
    bus.we     = 1'b1;
    bus.w_addr = 8'h13;
    bus.w_data = 32'd103;
    bus.r_req  = 1'b1;
    tick();
    bus.we     = 1'b0;
    bus.r_req  = 1'b0;
    chk("t4_count_same", 64'(bus.count),   64'(3));
    chk("t4_valid_n",    64'(bus.r_valid), 64'(0));
    tick();
    chk("t4_valid_n1",   64'(bus.r_valid), 64'(0));
    tick();
    chk("t4_valid_n2",   64'(bus.r_valid), 64'(1));
    chk("t4_data_oldest", 64'(bus.r_data), 64'(rec(8'h10, 32'd100)));
    tick();
    poll_expect("t4_p1", rec(8'h11, 32'd101));
    poll_expect("t4_p2", rec(8'h12, 32'd102));
    poll_expect("t4_p3", rec(8'h13, 32'd103));
    chk("t4_count_end", 64'(bus.count), 64'(0));

    // Write into an empty FIFO on the poll edge: poll sees nothing
    bus.we     = 1'b1;
    bus.w_addr = 8'h20;
    bus.w_data = 32'd200;
    bus.r_req  = 1'b1;
    tick();
    bus.we     = 1'b0;
    bus.r_req  = 1'b0;
    chk("t5_count_1", 64'(bus.count), 64'(1));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_no_valid_%0d", i), 64'(bus.r_valid), 64'(0));
      tick();
    end
    poll_expect("t5_next_poll", rec(8'h20, 32'd200));
    chk("t5_count_end", 64'(bus.count), 64'(0));

    // Reset during an in-flight pop
    write_rec(8'h30, 32'd300);
    write_rec(8'h31, 32'd301);
    chk("t6_count_2", 64'(bus.count), 64'(2));
    bus.r_req = 1'b1;
    tick();                                   // edge N
    bus.r_req = 1'b0;
    chk("t6_count_popped", 64'(bus.count), 64'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_count",    64'(bus.count),    64'(0));
    chk("t6_rst_overflow", 64'(bus.overflow), 64'(0));
    chk("t6_rst_valid",    64'(bus.r_valid),  64'(0));
    tick();                                   // edge N+1 under reset
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_post_valid_%0d", i), 64'(bus.r_valid), 64'(0));
      tick();
    end
    chk("t6_post_count",    64'(bus.count),    64'(0));
    chk("t6_post_overflow", 64'(bus.overflow), 64'(0));
    write_rec(8'h40, 32'd400);
    poll_expect("t6_new", rec(8'h40, 32'd400));
    chk("t6_count_end", 64'(bus.count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_s2m_responder
